ro_freq_meter: RTL and testbench

- Measurement-side companion to the on-chip ring-oscillator array.
- Gates the oscillator's enable, waits for settling, then counts RO output rising edges over a fixed window of system-clock cycles.
- Reports the edge count, so software can estimate RO frequency and track power and temperature drift during test-pattern runs.
- Sits between the RO macro (ro_enable out, ro_in back) and the test controller (start/done handshake).

---
 rtl/ro_meas_pkg.sv | 26 ++
 rtl/ro_edge_sync.sv | 62 ++++++
 rtl/ro_freq_meter.sv | 156 +++++++++++++++
 tb/tb_ro_freq_meter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
// Holds the measurement FSM state type, default parameter values and a helper
// that sizes the shared settle/gate timer.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCount,
    StDone
  } ro_state_e;

  localparam int unsigned DefGateCycles   = 1024;
  localparam int unsigned DefSettleCycles = 16;
  localparam int unsigned DefCntW         = 24;
  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefPrescaleLog2 = 4;

  // One timer serves both phases, so it must hold the larger of the two lengths.
  function automatic int unsigned timer_width(input int unsigned gate, input int unsigned settle);
    int unsigned longest;
    longest = (gate > settle) ? gate : settle;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Brings the asynchronous ring-oscillator output into the clk domain and
// produces a one-cycle pulse for every rising edge seen after synchronisation.
// Optional feature: with RO_PRESCALE_EN defined, ro_in first passes through a
// PRESCALE_LOG2-stage ripple divider clocked by ro_in itself.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   ro_in  - raw ring-oscillator output, asynchronous to clk
//   edge_o - single-cycle rising-edge pulse, clk domain
module ro_edge_sync
  import ro_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned PRESCALE_LOG2 = DefPrescaleLog2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic edge_o
);

  logic sync_src;

`ifdef RO_PRESCALE_EN
  // div_clk[i] clocks stage i; each stage halves the frequency of the one before.
  logic [PRESCALE_LOG2:0] div_clk;
  assign div_clk[0] = ro_in;

  for (genvar i = 0; i < int'(PRESCALE_LOG2); i++) begin : g_div
    logic stage_q;
    always_ff @(posedge div_clk[i] or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= 1'b0;
      end else begin
        stage_q <= ~stage_q;
      end
    end
    assign div_clk[i+1] = stage_q;
  end

  assign sync_src = div_clk[PRESCALE_LOG2];
`else
  assign sync_src = ro_in;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sync_src};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter. On start it enables the RO, waits
// SETTLE_CYCLES for it to stabilise, counts synchronised rising edges over a
// GATE_CYCLES window, then reports the saturating count with a done pulse.
// Optional feature: RO_PRESCALE_EN inserts a 2^PRESCALE_LOG2 divider ahead of
// the synchroniser (see ro_edge_sync).
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   start     - begin a measurement (honoured only when idle)
//   abort     - cancel a measurement during settle or count
//   ro_in     - raw ring-oscillator output, asynchronous to clk
//   ro_enable - enable to the RO macro
//   busy      - measurement in progress (settle or count)
//   done      - one-cycle pulse, count/overflow valid
//   count     - edge count of the last completed measurement
//   overflow  - last completed measurement saturated
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = DefGateCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned PRESCALE_LOG2 = DefPrescaleLog2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ro_in,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned TimerW = timer_width(GATE_CYCLES, SETTLE_CYCLES);
  localparam logic [TimerW-1:0] SettleLast = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0] GateLast   = TimerW'(GATE_CYCLES - 1);

  ro_state_e         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  work_cnt_q, work_cnt_d;
  logic              work_ovf_q, work_ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic             ro_edge;
  logic [CNT_W-1:0] inc_cnt;
  logic             inc_ovf;

  ro_edge_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .PRESCALE_LOG2(PRESCALE_LOG2)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_in (ro_in),
    .edge_o(ro_edge)
  );

  // Work counter value after this cycle's edge, saturating at all-ones.
  always_comb begin
    inc_cnt = work_cnt_q;
    inc_ovf = work_ovf_q;
    if (ro_edge) begin
      if (&work_cnt_q) begin
        inc_ovf = 1'b1;
      end else begin
        inc_cnt = work_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    work_cnt_d = work_cnt_q;
    work_ovf_d = work_ovf_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSettle;
          timer_d    = '0;
          work_cnt_d = '0;
          work_ovf_d = 1'b0;
        end
      end

      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (timer_q == SettleLast) begin
          state_d = StCount;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StCount: begin
        work_cnt_d = inc_cnt;
        work_ovf_d = inc_ovf;
        if (abort) begin
          state_d = StIdle;
        end else if (timer_q == GateLast) begin
          // Result registers load on entry to DONE so they are already valid
          // in the cycle where done is high; includes the final window edge.
          state_d = StDone;
          count_d = inc_cnt;
          ovf_d   = inc_ovf;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      work_cnt_q <= '0;
      work_ovf_q <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      work_cnt_q <= work_cnt_d;
      work_ovf_q <= work_ovf_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q == StSettle) || (state_q == StCount);
  assign ro_enable = busy;
  assign done      = (state_q == StDone);
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: window-based reference model plus directed checks.
module tb_ro_freq_meter;

  localparam int S  = 16;
  localparam int G  = 1024;
  localparam int SY = 2;
  localparam int W  = 24;
  localparam int MaxCnt = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n, start, abort, ro_in;
  logic ro_enable, busy, done, overflow;
  logic [W-1:0] count;

  logic start2;
  logic ro_enable2, busy2, done2, overflow2;
  logic [3:0] count2;

  int total = 0;
  int bad   = 0;

  always #8 clk = ~clk;

  ro_freq_meter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .ro_in    (ro_in),
    .ro_enable(ro_enable),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );

  ro_freq_meter #(
    .GATE_CYCLES(100),
    .CNT_W      (4)
  ) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .abort    (1'b0),
    .ro_in    (ro_in),
    .ro_enable(ro_enable2),
    .busy     (busy2),
    .done     (done2),
    .count    (count2),
    .overflow (overflow2)
  );

  // ---------------- RO stimulus: 0 static, 1 square, 2 random per cycle ----------------
  int   ro_mode   = 0;
  int   half_p    = 80;
  logic ro_static = 1'b0;

  initial begin
    ro_in = 1'b0;
    forever begin
      if (ro_mode == 1) begin
        @(negedge clk);
        #3;
        while (ro_mode == 1) begin
          #(half_p);
          ro_in = ~ro_in;
        end
      end else if (ro_mode == 2) begin
        @(posedge clk);
        #3;
        ro_in = 1'($urandom_range(0, 1));
      end else begin
        ro_in = ro_static;
        #1;
      end
    end
  end

  // ---------------- Reference model ----------------
  // samp[e] is ro_in as seen at posedge e (0 while the synchroniser is held in reset).
  // A measurement accepted at edge t counts every rising step of the sampled
  // stream whose synchronised copy appears during the window cycles
  // [t+S, t+S+G-1]; the sync chain delays the stream by SY-1 cycles.
  int       cyc = 0;
  bit       samp [65536];
  bit       m_act = 1'b0;
  int       m_t   = 0;
  int       m_cnt = 0;
  bit       m_ovf = 1'b0;
  bit       chk_on = 1'b0;

  function automatic int phase(input int c);  // 0 idle, 1 busy, 2 done
    if (!m_act || c < m_t) return 0;
    if (c < m_t + S + G) return 1;
    if (c == m_t + S + G) return 2;
    return 0;
  endfunction

  function automatic void close_window();
    int raw = 0;
    for (int c = m_t + S; c < m_t + S + G; c++) begin
      if (samp[c-SY+1] && !samp[c-SY]) raw++;
    end
    m_cnt = (raw > MaxCnt) ? MaxCnt : raw;
    m_ovf = (raw > MaxCnt);
  endfunction

  initial forever begin
    int p;
    @(posedge clk);
    cyc = cyc + 1;
    samp[cyc] = rst_n ? ro_in : 1'b0;
    if (rst_n) begin
      p = phase(cyc - 1);
      if (p == 0 && start) begin
        m_act = 1'b1;
        m_t   = cyc;
      end else if (p == 1 && abort) begin
        m_act = 1'b0;
      end
      if (m_act && cyc == m_t + S + G) close_window();
    end
  end

  initial forever begin
    @(negedge rst_n);
    m_act = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    for (int k = cyc - 3; k <= cyc; k++) if (k >= 0) samp[k] = 1'b0;
  end

  // ---------------- Per-cycle scoreboard ----------------
  initial forever begin
    logic [W+3:0] exp_v, got_v;
    int p;
    @(negedge clk);
    if (chk_on) begin
      p     = phase(cyc);
      exp_v = {p == 1, p == 1, p == 2, m_ovf, W'(m_cnt)};
      got_v = {ro_enable, busy, done, overflow, count};
`ifdef RO_PRESCALE_EN
      exp_v[W:0] = '0;
      got_v[W:0] = '0;
`endif
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
      end
    end
  end

  // ---------------- Helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic do_start(output int t);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t     = cyc;
    start = 1'b0;
  endtask

  // Returns the cycle in which done was high (-1 on timeout) and ro_enable cycles seen.
  task automatic wait_done(input string name, input int bound, output int dc, output int en_cyc);
    dc     = -1;
    en_cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ro_enable) en_cyc++;
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=none want=done within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_done2(input string name, output int dc);
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done2) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=none want=done2", name);
    end
  endtask

  initial begin
    #(16 * 60000);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- Directed and random sequences ----------------
  initial begin
    int t, dc, en, prev, seen;
    rst_n  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    #2;
    rst_n  = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {ro_enable, busy, done, overflow, count}, 0);

`ifndef RO_PRESCALE_EN
    // Static input: no edges.
    do_start(t);
    wait_done("static", 1200, dc, en);
    chk("static_latency", dc - t, 1040);
    chk("static_count", count, 0);
    chk("static_ovf", overflow, 0);

    // Square wave, period 10 clk.
    ro_mode = 1;
    half_p  = 80;
    repeat (20) @(negedge clk);
    do_start(t);
    wait_done("sq10", 1200, dc, en);
    chk("sq10_latency", dc - t, 1040);
    chk_range("sq10_count", count, 102, 103);
    chk("sq10_ovf", overflow, 0);
    chk("sq10_enable_cycles", en, 1040);

    // Start while busy is ignored.
    do_start(t);
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart", 1200, dc, en);
    chk("restart_latency", dc - t, 1040);
    prev = count;

    // Abort 500 cycles into the count window.
    do_start(t);
    for (int i = 0; i < 1000 && cyc < t + S + 500; i++) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_enable_low", ro_enable, 0);
    chk("abort_busy_low", busy, 0);
    seen = 0;
    repeat (1100) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_count_held", count, prev);

    // Asynchronous reset in the middle of the count window.
    do_start(t);
    repeat (600) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {ro_enable, busy, done, overflow, count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(t);
    wait_done("after_reset", 1200, dc, en);
    chk("after_reset_latency", dc - t, 1040);
    chk_range("after_reset_count", count, 102, 103);

    // Random RO activity with random starts and rare aborts.
    ro_mode = 2;
    repeat (9000) begin
      @(negedge clk);
      start = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 2499) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (1100) @(negedge clk);

    // Narrow counter saturates, then recovers with a static input.
    ro_mode = 1;
    half_p  = 32;
    repeat (10) @(negedge clk);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done2("sat", dc);
    chk("sat_count", count2, 15);
    chk("sat_ovf", overflow2, 1);
    ro_mode   = 0;
    ro_static = 1'b0;
    repeat (10) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done2("sat_clear", dc);
    chk("sat_clear_count", count2, 0);
    chk("sat_clear_ovf", overflow2, 0);
`else
    // Prescaled: RO period 1.25 clk divided by 16 over the 1024-cycle gate.
    ro_mode = 1;
    half_p  = 10;
    repeat (20) @(negedge clk);
    do_start(t);
    wait_done("prescale", 1200, dc, en);
    chk("prescale_latency", dc - t, 1040);
    chk_range("prescale_count", count, 51, 52);
    chk("prescale_ovf", overflow, 0);
`endif

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
